// File: rtl/act_unit_scheduler_pkg.sv
// Shared constants, FSM state encoding and index-width helper for the
// activation-unit scheduler.
package act_unit_scheduler_pkg;

  localparam int DATA_W     = 8;
  localparam int LUT_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of the neuron index counter; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/act_unit_scheduler_if.sv
// Bundle of the layer-side and activation-unit-side signals of the scheduler.
// The scheduler uses the slave view; the surrounding layer logic uses master.
interface act_unit_scheduler_if #(
  parameter int N = 4
);
  import act_unit_scheduler_pkg::*;

  logic                start;
  logic [N*DATA_W-1:0] z_vec;
  logic                busy;
  logic                done;
  logic [N*DATA_W-1:0] a_vec;
  logic [DATA_W-1:0]   act_z;
  logic                act_issue;
  logic [DATA_W-1:0]   act_a;

  modport master (
    output start, z_vec, act_a,
    input  busy, done, a_vec, act_z, act_issue
  );

  modport slave (
    input  start, z_vec, act_a,
    output busy, done, a_vec, act_z, act_issue
  );

endinterface

// File: rtl/act_unit_scheduler_tag_pipe.sv
// Tag pipe: carries {valid, index} alongside the activation unit so each
// result is written back to the neuron slot it was issued from.
module act_tag_pipe
  import act_unit_scheduler_pkg::*;
#(
  parameter int N = 4,
  parameter int ACT_LAT = 0,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [IW-1:0] in_idx,
  output logic          out_valid,
  output logic [IW-1:0] out_idx
);

  if (ACT_LAT == 0) begin : g_pass
    // A combinational unit needs no delay; clk and rst have no role here.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_valid = in_valid;
    assign out_idx   = in_idx;
  end else begin : g_pipe
    logic          valid_q [ACT_LAT];
    logic [IW-1:0] idx_q   [ACT_LAT];

    // Advance every tag one stage per cycle, matching the unit's pipeline.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < ACT_LAT; k++) begin
          valid_q[k] <= 1'b0;
          idx_q[k]   <= '0;
        end
      end else begin
        valid_q[0] <= in_valid;
        idx_q[0]   <= in_idx;
        for (int k = 1; k < ACT_LAT; k++) begin
          valid_q[k] <= valid_q[k-1];
          idx_q[k]   <= idx_q[k-1];
        end
      end
    end

    assign out_valid = valid_q[ACT_LAT-1];
    assign out_idx   = idx_q[ACT_LAT-1];
  end

endmodule

// File: rtl/act_unit_scheduler.sv
// Time-shares one activation unit across the N neurons of a layer: latches
// the pre-activations on start, issues one per cycle, gathers the results.
module act_unit_scheduler
  import act_unit_scheduler_pkg::*;
#(
  parameter int N = 4,
  parameter int ACT_LAT = 0
) (
  input logic                 clk,
  input logic                 rst,
  act_unit_scheduler_if.slave bus
);

  localparam int            IW         = idx_w(N);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
  localparam logic [1:0]    DRAIN_INIT = 2'((ACT_LAT > 0) ? ACT_LAT - 1 : 0);

  state_t              state;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       next_idx;
  logic [1:0]          drain_cnt;
  logic [N*DATA_W-1:0] zbuf;
  logic [N*DATA_W-1:0] a_q;
  logic                busy_q;
  logic                done_q;
  logic                issue_q;
  logic [DATA_W-1:0]   act_z_q;
  logic                cap_valid;
  logic [IW-1:0]       cap_idx;

  assign next_idx = idx + 1'b1;

  // Pass sequencer; the operand for the next cycle is registered one edge ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      drain_cnt <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      issue_q   <= 1'b0;
      act_z_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            zbuf    <= bus.z_vec;
            idx     <= '0;
            issue_q <= 1'b1;
            busy_q  <= 1'b1;
            act_z_q <= bus.z_vec[DATA_W-1:0];
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (idx == LAST_IDX) begin
            idx     <= '0;
            issue_q <= 1'b0;
            act_z_q <= '0;
            if (ACT_LAT > 0) begin
              drain_cnt <= DRAIN_INIT;
              state     <= DRAIN;
            end else begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end else begin
            idx     <= next_idx;
            act_z_q <= zbuf[next_idx*DATA_W +: DATA_W];
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd0) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  act_tag_pipe #(
    .N       (N),
    .ACT_LAT (ACT_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_q),
    .in_idx    (idx),
    .out_valid (cap_valid),
    .out_idx   (cap_idx)
  );

  // Store each returning result bit-exact into the slot its tag names.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
    end else if (cap_valid && (state == ISSUE || state == DRAIN)) begin
      a_q[cap_idx*DATA_W +: DATA_W] <= bus.act_a;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.act_issue = issue_q;
  assign bus.act_z     = act_z_q;
  assign bus.a_vec     = a_q;

endmodule

// File: tb/tb_act_unit_scheduler.sv
// Self-checking bench: one scheduler with a combinational unit, one with a
// two-stage pipelined unit, both compared against a cycle-level model.
module tb_act_unit_scheduler;
  import act_unit_scheduler_pkg::*;

  localparam int N    = 4;
  localparam int MAXC = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0;
  logic rst2;
  logic unit_lut;

  act_unit_scheduler_if #(.N(N)) if0 ();
  act_unit_scheduler_if #(.N(N)) if2 ();

  act_unit_scheduler #(.N(N), .ACT_LAT(0)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
  act_unit_scheduler #(.N(N), .ACT_LAT(2)) dut2 (.clk(clk), .rst(rst2), .bus(if2));

  int lut_tab [17] = '{-127, -126, -124, -120, -112, -96, -72, -40, 0,
                       40, 72, 96, 112, 120, 124, 126, 127};

  // Reference activation: 16-segment LUT on the upper nibble, linear blend on the lower.
  function automatic logic [7:0] act_ref(input logic [7:0] z);
    int k;
    int f;
    int r;
    k = int'({~z[7], z[6:4]});
    f = int'(z[3:0]);
    r = lut_tab[k] + ((lut_tab[k+1] - lut_tab[k]) * f) / 16;
    return r[7:0];
  endfunction

  function automatic logic [7:0] unit_model(input logic [7:0] z, input logic lut);
    return lut ? act_ref(z) : z + 8'd1;
  endfunction

  logic [7:0] pipe_a;
  logic [7:0] pipe_b;
  assign if0.act_a = unit_model(if0.act_z, unit_lut);
  always @(posedge clk) begin
    pipe_a <= if2.act_z + 8'd1;
    pipe_b <= pipe_a;
  end
  assign if2.act_a = pipe_b;

  logic        stim_start [MAXC];
  logic        stim_rst   [MAXC];
  logic [31:0] stim_z     [MAXC];
  logic        exp_issue  [MAXC];
  logic        exp_busy   [MAXC];
  logic        exp_done   [MAXC];
  logic [7:0]  exp_z      [MAXC];
  logic [31:0] exp_a      [MAXC];
  logic        obs_issue  [MAXC];
  logic        obs_busy   [MAXC];
  logic        obs_done   [MAXC];
  logic [7:0]  obs_z      [MAXC];
  logic [31:0] obs_a      [MAXC];
  logic [31:0] model_a0 = '0;
  logic [31:0] model_a2 = '0;
  int total = 0;
  int bad   = 0;

  task automatic clear_stim(input logic [31:0] z);
    for (int c = 0; c < MAXC; c++) begin
      stim_start[c] = 1'b0;
      stim_rst[c]   = 1'b0;
      stim_z[c]     = z;
    end
  endtask

  // Cycle-level expectations derived from the timing and capture rules.
  task automatic build_model(input int lat, input logic lut, input int ncyc);
    int next_ok;
    logic [31:0] a_init;
    next_ok = 0;
    a_init = (lat == 0) ? model_a0 : model_a2;
    for (int c = 0; c < MAXC; c++) begin
      exp_issue[c] = 1'b0; exp_busy[c] = 1'b0; exp_done[c] = 1'b0;
      exp_z[c] = '0; exp_a[c] = a_init;
    end
    for (int c = 0; c < ncyc; c++) begin
      if (stim_rst[c]) begin
        for (int t = c + 1; t < ncyc; t++) begin
          exp_issue[t] = 1'b0; exp_busy[t] = 1'b0; exp_done[t] = 1'b0;
          exp_z[t] = '0; exp_a[t] = '0;
        end
        next_ok = c + 1;
      end else if (stim_start[c] && c >= next_ok) begin
        for (int j = 0; j < N; j++) begin
          if (c + 1 + j < ncyc) begin
            exp_issue[c+1+j] = 1'b1;
            exp_z[c+1+j] = stim_z[c][j*8 +: 8];
          end
          for (int t = c + 2 + j + lat; t < ncyc; t++)
            exp_a[t][j*8 +: 8] = unit_model(stim_z[c][j*8 +: 8], lut);
        end
        for (int t = c + 1; t <= c + N + lat && t < ncyc; t++) exp_busy[t] = 1'b1;
        if (c + N + lat + 1 < ncyc) exp_done[c+N+lat+1] = 1'b1;
        next_ok = c + N + lat + 2;
      end
    end
    if (lat == 0) model_a0 = exp_a[ncyc-1];
    else          model_a2 = exp_a[ncyc-1];
  endtask

  // Drive the stimulus table into one scheduler and record its outputs per cycle.
  task automatic run_cycles(input int lat, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      if (lat == 0) begin
        rst0 = stim_rst[c]; if0.start = stim_start[c]; if0.z_vec = stim_z[c];
        obs_issue[c] = if0.act_issue; obs_busy[c] = if0.busy; obs_done[c] = if0.done;
        obs_z[c] = if0.act_z; obs_a[c] = if0.a_vec;
      end else begin
        rst2 = stim_rst[c]; if2.start = stim_start[c]; if2.z_vec = stim_z[c];
        obs_issue[c] = if2.act_issue; obs_busy[c] = if2.busy; obs_done[c] = if2.done;
        obs_z[c] = if2.act_z; obs_a[c] = if2.a_vec;
      end
      @(posedge clk);
      #1;
    end
    rst0 = 1'b0; rst2 = 1'b0; if0.start = 1'b0; if2.start = 1'b0;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total += 5;
    if (if0.busy !== 1'b0)      begin bad++; $display("[TB] FAIL reset busy0 got=%b exp=0", if0.busy); end
    if (if0.done !== 1'b0)      begin bad++; $display("[TB] FAIL reset done0 got=%b exp=0", if0.done); end
    if (if0.act_issue !== 1'b0) begin bad++; $display("[TB] FAIL reset issue0 got=%b exp=0", if0.act_issue); end
    if (if0.act_z !== 8'h00)    begin bad++; $display("[TB] FAIL reset act_z0 got=%h exp=00", if0.act_z); end
    if (if0.a_vec !== 32'h0)    begin bad++; $display("[TB] FAIL reset a_vec0 got=%h exp=0", if0.a_vec); end
    total += 5;
    if (if2.busy !== 1'b0)      begin bad++; $display("[TB] FAIL reset busy2 got=%b exp=0", if2.busy); end
    if (if2.done !== 1'b0)      begin bad++; $display("[TB] FAIL reset done2 got=%b exp=0", if2.done); end
    if (if2.act_issue !== 1'b0) begin bad++; $display("[TB] FAIL reset issue2 got=%b exp=0", if2.act_issue); end
    if (if2.act_z !== 8'h00)    begin bad++; $display("[TB] FAIL reset act_z2 got=%h exp=00", if2.act_z); end
    if (if2.a_vec !== 32'h0)    begin bad++; $display("[TB] FAIL reset a_vec2 got=%h exp=0", if2.a_vec); end
    rst0 = 1'b0; rst2 = 1'b0;
    model_a0 = '0; model_a2 = '0;
  endtask

  task automatic test_basic();
    logic [31:0] zv;
    unit_lut = 1'b0;
    for (int p = 0; p < 4; p++) begin
      zv = (p == 0) ? 32'h04030201 : $urandom;
      clear_stim(zv);
      stim_start[0] = 1'b1;
      build_model(0, 1'b0, 9);
      run_cycles(0, 9);
      for (int c = 0; c < 9; c++) begin
        total += 4;
        if (obs_issue[c] !== exp_issue[c]) begin bad++; $display("[TB] FAIL basic issue c=%0d got=%b exp=%b", c, obs_issue[c], exp_issue[c]); end
        if (obs_busy[c] !== exp_busy[c])   begin bad++; $display("[TB] FAIL basic busy c=%0d got=%b exp=%b", c, obs_busy[c], exp_busy[c]); end
        if (obs_done[c] !== exp_done[c])   begin bad++; $display("[TB] FAIL basic done c=%0d got=%b exp=%b", c, obs_done[c], exp_done[c]); end
        if (obs_a[c] !== exp_a[c])         begin bad++; $display("[TB] FAIL basic a_vec c=%0d got=%h exp=%h", c, obs_a[c], exp_a[c]); end
        if (exp_issue[c]) begin
          total++;
          if (obs_z[c] !== exp_z[c]) begin bad++; $display("[TB] FAIL basic act_z c=%0d got=%h exp=%h", c, obs_z[c], exp_z[c]); end
        end
      end
      if (p == 0) begin
        total += 2;
        if (obs_done[5] !== 1'b1)       begin bad++; $display("[TB] FAIL basic done5 got=%b exp=1", obs_done[5]); end
        if (obs_a[5] !== 32'h05040302) begin bad++; $display("[TB] FAIL basic result got=%h exp=05040302", obs_a[5]); end
      end
    end
  endtask

  task automatic test_pipelined();
    logic [31:0] zv;
    for (int p = 0; p < 3; p++) begin
      zv = (p == 0) ? 32'h04030201 : $urandom;
      clear_stim(zv);
      stim_start[0] = 1'b1;
      build_model(2, 1'b0, 11);
      run_cycles(2, 11);
      for (int c = 0; c < 11; c++) begin
        total += 4;
        if (obs_issue[c] !== exp_issue[c]) begin bad++; $display("[TB] FAIL pipe issue c=%0d got=%b exp=%b", c, obs_issue[c], exp_issue[c]); end
        if (obs_busy[c] !== exp_busy[c])   begin bad++; $display("[TB] FAIL pipe busy c=%0d got=%b exp=%b", c, obs_busy[c], exp_busy[c]); end
        if (obs_done[c] !== exp_done[c])   begin bad++; $display("[TB] FAIL pipe done c=%0d got=%b exp=%b", c, obs_done[c], exp_done[c]); end
        if (obs_a[c] !== exp_a[c])         begin bad++; $display("[TB] FAIL pipe a_vec c=%0d got=%h exp=%h", c, obs_a[c], exp_a[c]); end
        if (exp_issue[c]) begin
          total++;
          if (obs_z[c] !== exp_z[c]) begin bad++; $display("[TB] FAIL pipe act_z c=%0d got=%h exp=%h", c, obs_z[c], exp_z[c]); end
        end
      end
      if (p == 0) begin
        total += 3;
        if (obs_done[7] !== 1'b1)       begin bad++; $display("[TB] FAIL pipe done7 got=%b exp=1", obs_done[7]); end
        if (obs_busy[6] !== 1'b1)       begin bad++; $display("[TB] FAIL pipe busy6 got=%b exp=1", obs_busy[6]); end
        if (obs_a[7] !== 32'h05040302) begin bad++; $display("[TB] FAIL pipe result got=%h exp=05040302", obs_a[7]); end
      end
    end
  endtask

  task automatic test_signed_boundary();
    logic [31:0] zv;
    logic [7:0] bz [4];
    bz[0] = 8'h80; bz[1] = 8'h7F; bz[2] = 8'h00; bz[3] = 8'hFF;
    unit_lut = 1'b1;
    for (int p = 0; p < 3; p++) begin
      zv = (p == 0) ? 32'hFF007F80 : $urandom;
      clear_stim(zv);
      stim_start[0] = 1'b1;
      build_model(0, 1'b1, 8);
      run_cycles(0, 8);
      for (int j = 0; j < N; j++) begin
        total++;
        if (obs_z[j+1] !== exp_z[j+1]) begin bad++; $display("[TB] FAIL signed act_z j=%0d got=%h exp=%h", j, obs_z[j+1], exp_z[j+1]); end
        total++;
        if (obs_a[5][j*8 +: 8] !== unit_model(zv[j*8 +: 8], 1'b1))
          begin bad++; $display("[TB] FAIL signed a j=%0d got=%h exp=%h", j, obs_a[5][j*8 +: 8], unit_model(zv[j*8 +: 8], 1'b1)); end
        if (p == 0) begin
          total++;
          if (obs_z[j+1] !== bz[j]) begin bad++; $display("[TB] FAIL signed edge j=%0d got=%h exp=%h", j, obs_z[j+1], bz[j]); end
        end
      end
    end
    unit_lut = 1'b0;
  endtask

  task automatic test_start_ignored();
    logic [31:0] za;
    logic [31:0] zb;
    za = $urandom;
    zb = za ^ 32'h5A5A5A5A;
    clear_stim(za);
    for (int c = 0; c < 13; c++) stim_start[c] = 1'b1;
    for (int c = 2; c < MAXC; c++) stim_z[c] = zb;
    build_model(0, 1'b0, 20);
    run_cycles(0, 20);
    for (int c = 0; c < 20; c++) begin
      total += 2;
      if (obs_issue[c] !== exp_issue[c]) begin bad++; $display("[TB] FAIL ignore issue c=%0d got=%b exp=%b", c, obs_issue[c], exp_issue[c]); end
      if (obs_done[c] !== exp_done[c])   begin bad++; $display("[TB] FAIL ignore done c=%0d got=%b exp=%b", c, obs_done[c], exp_done[c]); end
      if (exp_issue[c]) begin
        total++;
        if (obs_z[c] !== exp_z[c]) begin bad++; $display("[TB] FAIL ignore act_z c=%0d got=%h exp=%h", c, obs_z[c], exp_z[c]); end
      end
    end
    total += 2;
    if (obs_z[3] !== za[23:16]) begin bad++; $display("[TB] FAIL ignore zbuf got=%h exp=%h", obs_z[3], za[23:16]); end
    if (obs_done[11] !== 1'b1)  begin bad++; $display("[TB] FAIL ignore second_done got=%b exp=1", obs_done[11]); end
  endtask

  task automatic test_reset_mid();
    clear_stim(32'h04030201);
    stim_start[0] = 1'b1;
    stim_rst[3]   = 1'b1;
    stim_start[5] = 1'b1;
    for (int c = 5; c < MAXC; c++) stim_z[c] = $urandom;
    build_model(0, 1'b0, 14);
    run_cycles(0, 14);
    for (int c = 0; c < 14; c++) begin
      total += 4;
      if (obs_issue[c] !== exp_issue[c]) begin bad++; $display("[TB] FAIL rstmid issue c=%0d got=%b exp=%b", c, obs_issue[c], exp_issue[c]); end
      if (obs_busy[c] !== exp_busy[c])   begin bad++; $display("[TB] FAIL rstmid busy c=%0d got=%b exp=%b", c, obs_busy[c], exp_busy[c]); end
      if (obs_done[c] !== exp_done[c])   begin bad++; $display("[TB] FAIL rstmid done c=%0d got=%b exp=%b", c, obs_done[c], exp_done[c]); end
      if (obs_a[c] !== exp_a[c])         begin bad++; $display("[TB] FAIL rstmid a_vec c=%0d got=%h exp=%h", c, obs_a[c], exp_a[c]); end
    end
    total += 3;
    if (obs_a[4] !== 32'h0)     begin bad++; $display("[TB] FAIL rstmid cleared got=%h exp=0", obs_a[4]); end
    if (obs_done[5] !== 1'b0)   begin bad++; $display("[TB] FAIL rstmid stale_done got=%b exp=0", obs_done[5]); end
    if (obs_done[10] !== 1'b1)  begin bad++; $display("[TB] FAIL rstmid fresh_done got=%b exp=1", obs_done[10]); end
  endtask

  task automatic test_back_to_back();
    clear_stim(32'h04030201);
    stim_start[0]  = 1'b1;
    stim_start[6]  = 1'b1;
    stim_start[12] = 1'b1;
    for (int c = 6; c < MAXC; c++) stim_z[c] = 32'h281E140A;
    for (int c = 12; c < MAXC; c++) stim_z[c] = $urandom;
    build_model(0, 1'b0, 20);
    run_cycles(0, 20);
    for (int c = 0; c < 20; c++) begin
      total += 2;
      if (obs_done[c] !== exp_done[c]) begin bad++; $display("[TB] FAIL b2b done c=%0d got=%b exp=%b", c, obs_done[c], exp_done[c]); end
      if (obs_a[c] !== exp_a[c])       begin bad++; $display("[TB] FAIL b2b a_vec c=%0d got=%h exp=%h", c, obs_a[c], exp_a[c]); end
    end
    total += 3;
    if (obs_done[5] !== 1'b1)       begin bad++; $display("[TB] FAIL b2b done5 got=%b exp=1", obs_done[5]); end
    if (obs_done[11] !== 1'b1)      begin bad++; $display("[TB] FAIL b2b done11 got=%b exp=1", obs_done[11]); end
    if (obs_a[11] !== 32'h291F150B) begin bad++; $display("[TB] FAIL b2b result got=%h exp=291F150B", obs_a[11]); end
  endtask

  initial begin
    rst0 = 1'b1; rst2 = 1'b1; unit_lut = 1'b0;
    if0.start = 1'b0; if0.z_vec = '0;
    if2.start = 1'b0; if2.z_vec = '0;
    @(posedge clk);
    #1;
    $display("[TB] starting act_unit_scheduler checks");
    test_reset();
    test_basic();
    test_pipelined();
    test_signed_boundary();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
